// File: rtl/axi_rd_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_resp_pkg
// Purpose  : Shared encodings and types for the AXI4 read-channel responder:
//            burst and response encodings, FSM state enum and the latched
//            AR request record.
// Revision : 1.0  initial release
// ============================================================================
package axi_rd_resp_pkg;

    localparam logic [1:0] C_BURST_FIXED = 2'b00;
    localparam logic [1:0] C_BURST_INCR  = 2'b01;
    localparam logic [1:0] C_BURST_WRAP  = 2'b10;

    localparam logic [1:0] C_RESP_OKAY   = 2'b00;
    localparam logic [1:0] C_RESP_SLVERR = 2'b10;

    // Address field is carried at a fixed wide width; the top masks it down
    // to the configured AR address width so arithmetic wraps correctly.
    localparam int C_AR_ADDR_W = 64;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    typedef struct packed {
        logic [C_AR_ADDR_W-1:0] addr;
        logic [7:0]             len;
        logic [2:0]             size;
        logic [1:0]             burst;
        logic [3:0]             id;
    } ar_req_t;

endpackage
`default_nettype wire

// File: rtl/axi_rd_resp_skid.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_resp_skid
// Purpose  : Two-entry R-channel output buffer carrying {data, resp, id, last}.
//            The entry being written is loaded straight from the memory read,
//            so the buffer register doubles as the memory output register.
// Ports    : clk_i/rst_ni      clock, async active-low reset
//            push_*_i          beat written this cycle (caller guarantees
//                              count_o < 2 when push_i is high)
//            valid_o/ready_i   R handshake, outputs taken from the head entry
//            count_o           current occupancy (0..2), used as read credit
// Revision : 1.0  initial release
// ============================================================================
module axi_rd_resp_skid #(
    parameter int P_DATA_WIDTH = 128
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  logic [P_DATA_WIDTH-1:0] push_data_i,
    input  logic [1:0]              push_resp_i,
    input  logic [3:0]              push_id_i,
    input  logic                    push_last_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [P_DATA_WIDTH-1:0] data_o,
    output logic [1:0]              resp_o,
    output logic [3:0]              id_o,
    output logic                    last_o,
    output logic [1:0]              count_o
);

    localparam int C_ENT_W = P_DATA_WIDTH + 7;

    logic [C_ENT_W-1:0] ent_q [2];
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [1:0]         count_q;
    logic [1:0]         count_d;
    logic               w_pop;

    assign valid_o = (count_q != 2'd0);
    assign w_pop   = valid_o && ready_i;
    assign count_o = count_q;

    // Head entry drives the bus; it is untouched while stalled because a
    // push with one entry occupied always lands in the other slot.
    assign {data_o, resp_o, id_o, last_o} = ent_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push_i, w_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ent_q[0] <= '0;
            ent_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                ent_q[wr_ptr_q] <= {push_data_i, push_resp_i, push_id_i, push_last_i};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_rd_responder.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_responder
// Purpose  : AXI4 read-channel slave backed by an internal word memory.
//            Accepts AR requests, reads one word per cycle and returns R
//            bursts with RID/RRESP/RLAST under RREADY backpressure. A backdoor
//            write port preloads memory.
// Ports    : i_axi_clk, i_rst_n          clock, async active-low reset
//            i_axi_ar* / o_axi_arready   AR channel
//            o_axi_r* / i_axi_rready     R channel
//            i_mem_wen/waddr/wdata       backdoor word write
// Options  : AXI_RD_RESP_OUTSTANDING_EN  adds a 2-entry AR queue so bursts
//            run back to back; undefined = one request at a time.
// Revision : 1.0  initial release
// ============================================================================
module axi_rd_responder
    import axi_rd_resp_pkg::*;
#(
    parameter int P_AXI_DATA_WIDTH = 128,
    parameter int P_AXI_ADDR_WIDTH = 32,
    parameter int P_MEM_DEPTH      = 1024
) (
    input  logic                           i_axi_clk,
    input  logic                           i_rst_n,
    input  logic                           i_axi_arvalid,
    output logic                           o_axi_arready,
    input  logic [P_AXI_ADDR_WIDTH-1:0]    i_axi_araddr,
    input  logic [7:0]                     i_axi_arlen,
    input  logic [2:0]                     i_axi_arsize,
    input  logic [1:0]                     i_axi_arburst,
    input  logic [3:0]                     i_axi_arid,
    output logic                           o_axi_rvalid,
    input  logic                           i_axi_rready,
    output logic [P_AXI_DATA_WIDTH-1:0]    o_axi_rdata,
    output logic [1:0]                     o_axi_rresp,
    output logic [3:0]                     o_axi_rid,
    output logic                           o_axi_rlast,
    input  logic                           i_mem_wen,
    input  logic [$clog2(P_MEM_DEPTH)-1:0] i_mem_waddr,
    input  logic [P_AXI_DATA_WIDTH-1:0]    i_mem_wdata
);

    localparam int         C_NB    = P_AXI_DATA_WIDTH / 8;
    localparam int         C_OFF   = $clog2(C_NB);
    localparam int         C_IDX_W = $clog2(P_MEM_DEPTH);
    localparam logic [2:0] C_SIZE  = 3'(C_OFF);
    localparam logic [C_AR_ADDR_W-1:0] C_ADDR_MASK =
        (P_AXI_ADDR_WIDTH >= C_AR_ADDR_W) ? {C_AR_ADDR_W{1'b1}}
                                          : ((C_AR_ADDR_W'(1) << P_AXI_ADDR_WIDTH) - C_AR_ADDR_W'(1));

    logic [P_AXI_DATA_WIDTH-1:0] mem_q [P_MEM_DEPTH];

    state_e                  state_q, state_d;
    ar_req_t                 cur_q, cur_d;
    logic [7:0]              beat_q, beat_d;
    logic                    rst_done_q;

    ar_req_t                 w_ar_req;
    logic                    w_ar_hs;
    logic [C_AR_ADDR_W-1:0]  w_addr;
    logic [C_AR_ADDR_W-1:0]  w_idx;
    logic [C_AR_ADDR_W-1:0]  w_addr_next;
    logic                    w_oob;
    logic                    w_err;
    logic                    w_last;
    logic                    w_issue;
    logic                    w_credit;
    logic [P_AXI_DATA_WIDTH-1:0] w_rd_data;
    logic [1:0]              w_skid_count;

    assign w_ar_hs        = i_axi_arvalid && o_axi_arready;
    assign w_ar_req.addr  = C_AR_ADDR_W'(i_axi_araddr);
    assign w_ar_req.len   = i_axi_arlen;
    assign w_ar_req.size  = i_axi_arsize;
    assign w_ar_req.burst = i_axi_arburst;
    assign w_ar_req.id    = i_axi_arid;

    // Beat address decode and error classification.
    assign w_addr      = cur_q.addr & C_ADDR_MASK;
    assign w_idx       = w_addr >> C_OFF;
    assign w_oob       = |(w_idx >> C_IDX_W);
    assign w_err       = w_oob || (cur_q.size != C_SIZE) ||
                         (cur_q.burst == C_BURST_WRAP) || (cur_q.burst == 2'b11);
    assign w_addr_next = (cur_q.addr + C_AR_ADDR_W'(C_NB)) & C_ADDR_MASK;
    assign w_last      = (beat_q == cur_q.len);
    assign w_rd_data   = w_err ? '0 : mem_q[w_idx[C_IDX_W-1:0]];

    // No separate memory pipeline stage: a read lands directly in the skid
    // buffer, so buffer occupancy alone is the outstanding-read credit.
    assign w_credit = (w_skid_count < 2'd2);

    // Backdoor write; a same-cycle R read samples mem_q before this update.
    always_ff @(posedge i_axi_clk) begin
        if (i_mem_wen) begin
            mem_q[i_mem_waddr] <= i_mem_wdata;
        end
    end

`ifdef AXI_RD_RESP_OUTSTANDING_EN
    ar_req_t    q_ent_q [2];
    logic       q_wp_q;
    logic       q_rp_q;
    logic [1:0] q_cnt_q;
    logic       w_q_push;
    logic       w_q_pop;

    assign o_axi_arready = rst_done_q && (q_cnt_q != 2'd2);

    always_ff @(posedge i_axi_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            q_ent_q[0] <= '0;
            q_ent_q[1] <= '0;
            q_wp_q     <= 1'b0;
            q_rp_q     <= 1'b0;
            q_cnt_q    <= 2'd0;
        end else begin
            if (w_q_push) begin
                q_ent_q[q_wp_q] <= w_ar_req;
                q_wp_q          <= ~q_wp_q;
            end
            if (w_q_pop) begin
                q_rp_q <= ~q_rp_q;
            end
            case ({w_q_push, w_q_pop})
                2'b10:   q_cnt_q <= q_cnt_q + 2'd1;
                2'b01:   q_cnt_q <= q_cnt_q - 2'd1;
                default: q_cnt_q <= q_cnt_q;
            endcase
        end
    end
`else
    assign o_axi_arready = rst_done_q && (state_q == ST_IDLE);
`endif

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        beat_d  = beat_q;
        w_issue = 1'b0;
`ifdef AXI_RD_RESP_OUTSTANDING_EN
        w_q_push = 1'b0;
        w_q_pop  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef AXI_RD_RESP_OUTSTANDING_EN
                // Queued requests go first; an empty queue lets a new AR be
                // loaded directly so single-request latency is unchanged.
                if (q_cnt_q != 2'd0) begin
                    cur_d    = q_ent_q[q_rp_q];
                    beat_d   = 8'd0;
                    state_d  = ST_BURST;
                    w_q_pop  = 1'b1;
                    w_q_push = w_ar_hs;
                end else if (w_ar_hs) begin
                    cur_d   = w_ar_req;
                    beat_d  = 8'd0;
                    state_d = ST_BURST;
                end
`else
                if (w_ar_hs) begin
                    cur_d   = w_ar_req;
                    beat_d  = 8'd0;
                    state_d = ST_BURST;
                end
`endif
            end
            ST_BURST: begin
`ifdef AXI_RD_RESP_OUTSTANDING_EN
                w_q_push = w_ar_hs;
`endif
                if (w_credit) begin
                    w_issue = 1'b1;
                    beat_d  = beat_q + 8'd1;
                    if (cur_q.burst == C_BURST_INCR) begin
                        cur_d.addr = w_addr_next;
                    end
                    if (w_last) begin
`ifdef AXI_RD_RESP_OUTSTANDING_EN
                        if (q_cnt_q != 2'd0) begin
                            cur_d   = q_ent_q[q_rp_q];
                            beat_d  = 8'd0;
                            w_q_pop = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_axi_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            beat_q     <= 8'd0;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            beat_q     <= beat_d;
            rst_done_q <= 1'b1;
        end
    end

    axi_rd_resp_skid #(
        .P_DATA_WIDTH (P_AXI_DATA_WIDTH)
    ) u_skid (
        .clk_i       (i_axi_clk),
        .rst_ni      (i_rst_n),
        .push_i      (w_issue),
        .push_data_i (w_rd_data),
        .push_resp_i (w_err ? C_RESP_SLVERR : C_RESP_OKAY),
        .push_id_i   (cur_q.id),
        .push_last_i (w_last),
        .valid_o     (o_axi_rvalid),
        .ready_i     (i_axi_rready),
        .data_o      (o_axi_rdata),
        .resp_o      (o_axi_rresp),
        .id_o        (o_axi_rid),
        .last_o      (o_axi_rlast),
        .count_o     (w_skid_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axi_rd_responder
// Purpose  : Directed self-checking bench for axi_rd_responder.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi_rd_responder;

    localparam int DW    = 128;
    localparam int AW    = 32;
    localparam int DEPTH = 1024;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            arvalid = 1'b0;
    logic            arready;
    logic [AW-1:0]   araddr = '0;
    logic [7:0]      arlen = '0;
    logic [2:0]      arsize = '0;
    logic [1:0]      arburst = '0;
    logic [3:0]      arid = '0;
    logic            rvalid;
    logic            rready = 1'b0;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic [3:0]      rid;
    logic            rlast;
    logic            mem_wen = 1'b0;
    logic [9:0]      mem_waddr = '0;
    logic [DW-1:0]   mem_wdata = '0;

    localparam logic [DW-1:0] TOP_WORD = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    always #5 clk = ~clk;

    axi_rd_responder #(
        .P_AXI_DATA_WIDTH (DW),
        .P_AXI_ADDR_WIDTH (AW),
        .P_MEM_DEPTH      (DEPTH)
    ) dut (
        .i_axi_clk     (clk),
        .i_rst_n       (rst_n),
        .i_axi_arvalid (arvalid),
        .o_axi_arready (arready),
        .i_axi_araddr  (araddr),
        .i_axi_arlen   (arlen),
        .i_axi_arsize  (arsize),
        .i_axi_arburst (arburst),
        .i_axi_arid    (arid),
        .o_axi_rvalid  (rvalid),
        .i_axi_rready  (rready),
        .o_axi_rdata   (rdata),
        .o_axi_rresp   (rresp),
        .o_axi_rid     (rid),
        .o_axi_rlast   (rlast),
        .i_mem_wen     (mem_wen),
        .i_mem_waddr   (mem_waddr),
        .i_mem_wdata   (mem_wdata)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Expected beat list for the next receive
    logic [DW-1:0] exp_d  [16];
    logic [1:0]    exp_r  [16];
    logic [3:0]    exp_id [16];
    logic          exp_l  [16];
    int            exp_n = 0;

    task automatic add_beat(input logic [DW-1:0] d, input logic [1:0] r,
                            input logic [3:0] id, input logic l);
        exp_d[exp_n]  = d;
        exp_r[exp_n]  = r;
        exp_id[exp_n] = id;
        exp_l[exp_n]  = l;
        exp_n++;
    endtask

    task automatic do_ar(input logic [AW-1:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input logic [3:0] id);
        int t = 0;
        arvalid = 1'b1; araddr = a; arlen = len; arsize = size;
        arburst = burst; arid = id;
        while (!arready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("ar_timeout", 256'(t), 256'd0);
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    // Receives exp_n beats starting at the current negedge; tog toggles
    // rready every cycle and checks that stalled outputs hold.
    task automatic rx(input bit tog, input string tag, output int cycles);
        int i = 0;
        int cyc = 0;
        bit ph = 1'b1;
        bit stalled = 1'b0;
        logic [DW+6:0] held = '0;
        while (i < exp_n && cyc < 100) begin
            rready = tog ? ph : 1'b1;
            ph = ~ph;
            if (stalled)
                check({tag, "_hold"}, 256'({rvalid, rdata, rresp, rid, rlast}), 256'({1'b1, held}));
            if (rvalid && rready) begin
                check({tag, "_data"}, 256'(rdata), 256'(exp_d[i]));
                check({tag, "_resp"}, 256'(rresp), 256'(exp_r[i]));
                check({tag, "_id"},   256'(rid),   256'(exp_id[i]));
                check({tag, "_last"}, 256'(rlast), 256'(exp_l[i]));
                i++;
            end
            stalled = rvalid && !rready;
            held = {rdata, rresp, rid, rlast};
            @(negedge clk);
            cyc++;
        end
        if (i < exp_n) check({tag, "_timeout"}, 256'(i), 256'(exp_n));
        rready = 1'b0;
        exp_n = 0;
        cycles = cyc;
    endtask

    initial begin
        int cyc;
        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_arready", 256'(arready), 256'd0);
        check("rst_rvalid",  256'(rvalid),  256'd0);
        check("rst_rdata",   256'(rdata),   256'd0);
        check("rst_rresp",   256'(rresp),   256'd0);
        check("rst_rid",     256'(rid),     256'd0);
        check("rst_rlast",   256'(rlast),   256'd0);
        rst_n = 1'b1;
        check("rel_arready0", 256'(arready), 256'd0);
        @(negedge clk);
        check("rel_arready1", 256'(arready), 256'd1);

        // ---------------- preload ----------------
        for (int k = 0; k < 16; k++) begin
            mem_wen = 1'b1; mem_waddr = 10'(k); mem_wdata = DW'(k);
            @(negedge clk);
        end
        mem_wen = 1'b1; mem_waddr = 10'(DEPTH - 1); mem_wdata = TOP_WORD;
        @(negedge clk);
        mem_wen = 1'b0;

        // ---------------- INCR burst, latency ----------------
        do_ar(32'h0, 8'd3, 3'd4, 2'b01, 4'd5);
        check("lat_cyc1", 256'(rvalid), 256'd0);
`ifndef AXI_RD_RESP_OUTSTANDING_EN
        check("arready_burst", 256'(arready), 256'd0);
`endif
        @(negedge clk);
        check("lat_cyc2", 256'(rvalid), 256'd1);
        for (int k = 0; k < 4; k++) add_beat(DW'(k), 2'b00, 4'd5, k == 3);
        rx(1'b0, "incr", cyc);
        check("incr_drain", 256'(rvalid), 256'd0);

        // ---------------- same burst, rready toggling ----------------
        do_ar(32'h0, 8'd3, 3'd4, 2'b01, 4'd5);
        for (int k = 0; k < 4; k++) add_beat(DW'(k), 2'b00, 4'd5, k == 3);
        rx(1'b1, "tog", cyc);
        @(negedge clk);
        check("tog_drain", 256'(rvalid), 256'd0);

        // ---------------- FIXED burst ----------------
        do_ar(32'h30, 8'd2, 3'd4, 2'b00, 4'd1);
        for (int k = 0; k < 3; k++) add_beat(DW'(3), 2'b00, 4'd1, k == 2);
        rx(1'b0, "fixed", cyc);

        // ---------------- end of memory ----------------
        do_ar(32'h3FF0, 8'd1, 3'd4, 2'b01, 4'd2);
        add_beat(TOP_WORD, 2'b00, 4'd2, 1'b0);
        add_beat('0,       2'b10, 4'd2, 1'b1);
        rx(1'b0, "edge", cyc);

        // ---------------- WRAP -> SLVERR ----------------
        do_ar(32'h10, 8'd1, 3'd4, 2'b10, 4'd3);
        add_beat('0, 2'b10, 4'd3, 1'b0);
        add_beat('0, 2'b10, 4'd3, 1'b1);
        rx(1'b0, "wrap", cyc);

        // ---------------- bad size -> SLVERR ----------------
        do_ar(32'h20, 8'd2, 3'd2, 2'b01, 4'd4);
        for (int k = 0; k < 3; k++) add_beat('0, 2'b10, 4'd4, k == 2);
        rx(1'b0, "size", cyc);

        // ---------------- reset mid-burst ----------------
        do_ar(32'h0, 8'd7, 3'd4, 2'b01, 4'd6);
        @(negedge clk);
        rready = 1'b1;
        @(negedge clk);
        check("mid_beat2", 256'(rdata), 256'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rvalid", 256'(rvalid), 256'd0);
        check("mid_arready", 256'(arready), 256'd0);
        rready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_arready", 256'(arready), 256'd1);
        check("post_rvalid", 256'(rvalid), 256'd0);
        do_ar(32'h40, 8'd1, 3'd4, 2'b01, 4'd7);
        add_beat(DW'(4), 2'b00, 4'd7, 1'b0);
        add_beat(DW'(5), 2'b00, 4'd7, 1'b1);
        rx(1'b0, "post", cyc);

        // ---------------- backdoor write colliding with read ----------------
        do_ar(32'h50, 8'd3, 3'd4, 2'b00, 4'd8);
        mem_wen = 1'b1; mem_waddr = 10'd5; mem_wdata = DW'(32'h55);
        @(negedge clk);
        mem_wen = 1'b0;
        add_beat(DW'(5), 2'b00, 4'd8, 1'b0);
        for (int k = 1; k < 4; k++) add_beat(DW'(32'h55), 2'b00, 4'd8, k == 3);
        rx(1'b0, "coll", cyc);

`ifdef AXI_RD_RESP_OUTSTANDING_EN
        // ---------------- back-to-back queued bursts ----------------
        do_ar(32'h0,  8'd1, 3'd4, 2'b01, 4'd1);
        do_ar(32'h20, 8'd1, 3'd4, 2'b01, 4'd2);
        add_beat(DW'(0), 2'b00, 4'd1, 1'b0);
        add_beat(DW'(1), 2'b00, 4'd1, 1'b1);
        add_beat(DW'(2), 2'b00, 4'd2, 1'b0);
        add_beat(DW'(3), 2'b00, 4'd2, 1'b1);
        rx(1'b0, "b2b", cyc);
        check("b2b_cycles", 256'(cyc), 256'd4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
